// File: rtl/sifre_pkg.sv
// sifre_pkg: shared state type and sizing constants for the code programmer.
// Holds the session FSM encoding and the digit/code widths used by
// sifre_programlayici and its timeout sub-module.
package sifre_pkg;
    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        GIRIS = 2'd1,
        ONAY  = 2'd2
    } durum_t;

    localparam int BASAMAK_SAYISI = 4;
    localparam int SIFRE_GENISLIK = 12;
    localparam int KILIT_GENISLIK = 6;
endpackage

// File: rtl/zaman_sayaci.sv
// zaman_sayaci: idle-cycle timeout counter for a programming session.
// Ports: clk, rst (async, active-high); temizle clears the count; etkin counts
// one idle cycle; doldu flags that this idle cycle is the ZAMAN_ASIMI-th one.
module zaman_sayaci #(
    parameter int ZAMAN_ASIMI = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic temizle,
    input  logic etkin,
    output logic doldu
);
    logic [15:0] sayac_q, sayac_d;

    always_comb sayac_d = temizle ? 16'd0 : etkin ? sayac_q + 16'd1 : sayac_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) sayac_q <= 16'd0;
        else     sayac_q <= sayac_d;

    // Fires during the idle cycle whose edge would bring the count to ZAMAN_ASIMI.
    assign doldu = etkin && !temizle && (sayac_q == 16'(ZAMAN_ASIMI - 1));
endmodule

// File: rtl/sifre_programlayici.sv
// sifre_programlayici: programs a two-lock dial code via entry + confirm passes.
// Ports: clk, rst (async, active-high); yaz_baslat starts a session;
// veri_gecerli/veri deliver 3-bit digits; kilit_sifreler holds the stored
// codes; mesgul marks an open session; tamam/hata pulse on commit/failure.
module sifre_programlayici
    import sifre_pkg::*;
#(
    parameter int ZAMAN_ASIMI = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      yaz_baslat,
    input  logic                      veri_gecerli,
    input  logic [2:0]                veri,
    output logic [SIFRE_GENISLIK-1:0] kilit_sifreler,
    output logic                      mesgul,
    output logic                      tamam,
    output logic                      hata
);
    durum_t                    durum_q, durum_d;
    logic [1:0]                basamak_q, basamak_d;
    logic [SIFRE_GENISLIK-1:0] giris_q, giris_d;
    logic [SIFRE_GENISLIK-1:0] onay_q, onay_d;
    logic [SIFRE_GENISLIK-1:0] kilit_q, kilit_d;
    logic                      mesgul_q, mesgul_d;
    logic                      tamam_q, tamam_d;
    logic                      hata_q, hata_d;
    logic                      kabul, son, doldu;

    assign kabul = veri_gecerli && (durum_q != BOSTA);
    assign son   = basamak_q == 2'(BASAMAK_SAYISI - 1);

    zaman_sayaci #(.ZAMAN_ASIMI(ZAMAN_ASIMI)) u_zaman (
        .clk    (clk),
        .rst    (rst),
        .temizle((durum_q == BOSTA) || kabul),
        .etkin  ((durum_q != BOSTA) && !veri_gecerli),
        .doldu  (doldu)
    );

    always_comb begin
        durum_d   = durum_q;
        basamak_d = basamak_q;
        giris_d   = giris_q;
        onay_d    = onay_q;
        kilit_d   = kilit_q;
        tamam_d   = 1'b0;
        hata_d    = 1'b0;
        case (durum_q)
            BOSTA: if (yaz_baslat) begin
                durum_d   = GIRIS;
                basamak_d = 2'd0;
            end
            GIRIS: if (kabul) begin
                giris_d   = {giris_q[SIFRE_GENISLIK-4:0], veri};
                basamak_d = basamak_q + 2'd1;
                if (son) durum_d = ONAY;
            end else if (doldu) begin
                durum_d = BOSTA;
                hata_d  = 1'b1;
            end
            ONAY: if (kabul) begin
                onay_d    = {onay_q[SIFRE_GENISLIK-4:0], veri};
                basamak_d = basamak_q + 2'd1;
                if (son) begin
                    durum_d = BOSTA;
                    if (onay_d == giris_q) begin
                        kilit_d = giris_q;
                        tamam_d = 1'b1;
                    end else begin
                        hata_d = 1'b1;
                    end
                end
            end else if (doldu) begin
                durum_d = BOSTA;
                hata_d  = 1'b1;
            end
            default: durum_d = BOSTA;
        endcase
        mesgul_d = durum_d != BOSTA;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            durum_q   <= BOSTA;
            basamak_q <= 2'd0;
            giris_q   <= '0;
            onay_q    <= '0;
            kilit_q   <= '0;
            mesgul_q  <= 1'b0;
            tamam_q   <= 1'b0;
            hata_q    <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            basamak_q <= basamak_d;
            giris_q   <= giris_d;
            onay_q    <= onay_d;
            kilit_q   <= kilit_d;
            mesgul_q  <= mesgul_d;
            tamam_q   <= tamam_d;
            hata_q    <= hata_d;
        end
    end

    assign kilit_sifreler = kilit_q;
    assign mesgul         = mesgul_q;
    assign tamam          = tamam_q;
    assign hata           = hata_q;
endmodule
